// File: rtl/pwm_duty_sched.sv
// pwm_duty_sched
//   Duty-cycle scheduler for the left/right motor pwm_gen instances. Takes target-duty
//   commands over a valid/ready port and holds at most one pending command. Each channel
//   slews toward its target by at most STEP per PWM period. Duty changes only on period
//   boundaries, so every pwm_gen period sees one constant duty.
//
//   Optional feature macro: PWM_SCHED_ESTOP_EN adds a synchronous emergency-stop input.
//
// Ports
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   estop        in   1       (PWM_SCHED_ESTOP_EN only) force duties/targets to 0, block commands
//   cmd_valid    in   1       command present
//   cmd_ready    out  1       scheduler can accept a command
//   cmd_chan     in   1       0 = left, 1 = right
//   cmd_duty     in   DUTY_W  requested target duty (clamped to DUTY_MAX on accept)
//   duty_l       out  DUTY_W  left duty, to left pwm_gen.duty
//   duty_r       out  DUTY_W  right duty, to right pwm_gen.duty
//   busy_l       out  1       left duty != left target
//   busy_r       out  1       right duty != right target
//   period_tick  out  1       one-cycle pulse on the last clock of each period

module pwm_duty_sched #(
    parameter int unsigned DUTY_W   = 10,
    parameter int unsigned PERIOD   = 1024,
    parameter int unsigned STEP     = 16,
    parameter int unsigned DUTY_MAX = 1020
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef PWM_SCHED_ESTOP_EN
    input  logic              estop,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_chan,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic [DUTY_W-1:0] duty_l,
    output logic [DUTY_W-1:0] duty_r,
    output logic              busy_l,
    output logic              busy_r,
    output logic              period_tick
);

    localparam logic [DUTY_W-1:0] CNT_LAST   = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX_V = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W:0]   STEP_EXT   = (DUTY_W + 1)'(STEP);

    typedef enum logic [1:0] {StIdle, StRampUp, StRampDn} ramp_e;

    function automatic ramp_e ramp_state(input logic [DUTY_W-1:0] cur,
                                         input logic [DUTY_W-1:0] eff);
        ramp_e st;
        st = StIdle;
        if (cur < eff) begin
            st = StRampUp;
        end else if (cur > eff) begin
            st = StRampDn;
        end
        return st;
    endfunction

    // One bounded slew step. The up-sum is one bit wider so it cannot wrap; the
    // down-subtraction only happens when cur > eff, so it cannot underflow.
    function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] cur,
                                               input logic [DUTY_W-1:0] eff,
                                               input ramp_e             st);
        logic [DUTY_W:0]   up_sum;
        logic [DUTY_W-1:0] dn_gap;
        logic [DUTY_W-1:0] nxt;
        nxt = cur;
        unique case (st)
            StRampUp: begin
                up_sum = {1'b0, cur} + STEP_EXT;
                nxt    = (up_sum > {1'b0, eff}) ? eff : up_sum[DUTY_W-1:0];
            end
            StRampDn: begin
                dn_gap = cur - eff;
                nxt    = ({1'b0, dn_gap} <= STEP_EXT) ? eff : cur - STEP_EXT[DUTY_W-1:0];
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    logic              estop_act;
`ifdef PWM_SCHED_ESTOP_EN
    assign estop_act = estop;
`else
    assign estop_act = 1'b0;
`endif

    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic              pend_q, pend_d;
    logic              pend_chan_q, pend_chan_d;
    logic [DUTY_W-1:0] pend_duty_q, pend_duty_d;
    logic              ready_q, ready_d;
    logic [DUTY_W-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic [DUTY_W-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
    logic              busy_l_q, busy_l_d, busy_r_q, busy_r_d;

    logic [DUTY_W-1:0] eff_l, eff_r;
    ramp_e             state_l, state_r;
    logic              accept;

    always_comb begin
        // A pending command for a channel overrides its stored target at the tick.
        eff_l   = (pend_q && !pend_chan_q) ? pend_duty_q : tgt_l_q;
        eff_r   = (pend_q &&  pend_chan_q) ? pend_duty_q : tgt_r_q;
        state_l = ramp_state(duty_l_q, eff_l);
        state_r = ramp_state(duty_r_q, eff_r);
    end

    always_comb begin
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d      = (cnt_d == CNT_LAST);
        accept      = cmd_valid & ready_q;

        pend_d      = pend_q;
        pend_chan_d = pend_chan_q;
        pend_duty_d = pend_duty_q;
        duty_l_d    = duty_l_q;
        duty_r_d    = duty_r_q;
        tgt_l_d     = tgt_l_q;
        tgt_r_d     = tgt_r_q;

        if (tick_q) begin
            tgt_l_d  = eff_l;
            tgt_r_d  = eff_r;
            duty_l_d = slew(duty_l_q, eff_l, state_l);
            duty_r_d = slew(duty_r_q, eff_r, state_r);
            pend_d   = 1'b0;
        end

        // accept implies pend_q == 0, so a tick in the same cycle saw no pending command.
        if (accept) begin
            pend_d      = 1'b1;
            pend_chan_d = cmd_chan;
            pend_duty_d = (cmd_duty > DUTY_MAX_V) ? DUTY_MAX_V : cmd_duty;
        end

        if (estop_act) begin
            duty_l_d = '0;
            duty_r_d = '0;
            tgt_l_d  = '0;
            tgt_r_d  = '0;
            pend_d   = 1'b0;
        end

        ready_d  = ~pend_d & ~estop_act;
        busy_l_d = (duty_l_d != tgt_l_d);
        busy_r_d = (duty_r_d != tgt_r_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_chan_q <= 1'b0;
            pend_duty_q <= '0;
            ready_q     <= 1'b1;
            duty_l_q    <= '0;
            duty_r_q    <= '0;
            tgt_l_q     <= '0;
            tgt_r_q     <= '0;
            busy_l_q    <= 1'b0;
            busy_r_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            pend_q      <= pend_d;
            pend_chan_q <= pend_chan_d;
            pend_duty_q <= pend_duty_d;
            ready_q     <= ready_d;
            duty_l_q    <= duty_l_d;
            duty_r_q    <= duty_r_d;
            tgt_l_q     <= tgt_l_d;
            tgt_r_q     <= tgt_r_d;
            busy_l_q    <= busy_l_d;
            busy_r_q    <= busy_r_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign duty_l      = duty_l_q;
    assign duty_r      = duty_r_q;
    assign busy_l      = busy_l_q;
    assign busy_r      = busy_r_q;
    assign period_tick = tick_q;

endmodule
